// File: rtl/video_timing_generator_pkg.sv
// Package: video_pkg
// Shared raster timing types for the display path.
//   timing_t         active/front porch/sync/back porch lengths for one axis
//   raster_t         horizontal plus vertical timing of a complete mode
//   VGA_640x480      standard 640x480@60 timing, the generator defaults
//   raster_flags_t   per-position decode flags that travel down the latency pipe
//   sync_pol_e       asserted level of the sync pulses
//   total()          full period of an axis (active + porches + sync)
//   cnt_width()      counter width able to hold 0..n-1, never narrower than 1 bit
package video_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } raster_t;

    localparam raster_t VGA_640x480 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2,  bp: 33}
    };

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // Field order matters: it is also the bit order inside the latency pipe.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } raster_flags_t;

    function automatic int total(input timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_timing_generator_tick_delay_line.sv
// Module: tick_delay_line
// Fixed-depth shift register that only advances when enable_i is high, so that a
// signal can be delayed by a number of pixel ticks rather than clock cycles.
//   clk_i      system clock
//   reset_ni   asynchronous active-low reset, all stages load RESET_VALUE
//   enable_i   advance the pipe by one stage
//   clear_i    synchronous clear of all stages to RESET_VALUE, wins over enable_i
//   data_i     value entering the first stage
//   data_o     value leaving the last stage (DEPTH enabled advances later)
module tick_delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = RESET_VALUE;
            end
        end else if (enable_i) begin
            stage_d[0] = data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_generator.sv
// Module: video_timing_generator
// Parametrised raster timing generator: pixel-tick divider, horizontal/vertical
// counters, sync pulses of selectable polarity, line/frame strobes and a
// completed-frame counter. Coordinates leave the block LATENCY ticks ahead of
// the sync/visible/strobe outputs so frame-buffer reads can be issued early.
// reset_ni asserts asynchronously; its release is expected to be synchronous to
// clk_i (provided by the system reset controller).
//   clk_i          system clock
//   reset_ni       asynchronous active-low reset
//   restart_i      synchronous restart of the raster at h=0, v=0
//   tick_o         pixel-tick strobe, one clk wide
//   hsync_o        horizontal sync at the SYNC_POL level while asserted
//   vsync_o        vertical sync at the SYNC_POL level while asserted
//   video_en_o     visible-area flag
//   x_o / y_o      column / row inside the visible area, 0 elsewhere
//   pixel_o        linear address y*H_ACTIVE+x, held outside the visible area
//   line_start_o   one clk pulse at the start of each line
//   frame_start_o  one clk pulse at the start of each frame
//   frame_count_o  completed frames, wraps
module video_timing_generator
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_640x480.h.active,
    parameter int H_FP      = VGA_640x480.h.fp,
    parameter int H_SYNC    = VGA_640x480.h.sync,
    parameter int H_BP      = VGA_640x480.h.bp,
    parameter int V_ACTIVE  = VGA_640x480.v.active,
    parameter int V_FP      = VGA_640x480.v.fp,
    parameter int V_SYNC    = VGA_640x480.v.sync,
    parameter int V_BP      = VGA_640x480.v.bp,
    parameter bit SYNC_POL  = 1'b0,
    parameter int PIXEL_DIV = 1,
    parameter int LATENCY   = 0,
    parameter int FRAME_W   = 16
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic                                restart_i,
    output logic                                tick_o,
    output logic                                hsync_o,
    output logic                                vsync_o,
    output logic                                video_en_o,
    output logic [$clog2(H_ACTIVE):0]           x_o,
    output logic [$clog2(V_ACTIVE):0]           y_o,
    output logic [$clog2(H_ACTIVE*V_ACTIVE):0]  pixel_o,
    output logic                                line_start_o,
    output logic                                frame_start_o,
    output logic [FRAME_W-1:0]                  frame_count_o
);

    localparam int H_TOTAL = total(timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP});
    localparam int V_TOTAL = total(timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP});
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);
    localparam int DW      = cnt_width(PIXEL_DIV);
    localparam int XW      = $clog2(H_ACTIVE) + 1;
    localparam int YW      = $clog2(V_ACTIVE) + 1;
    localparam int PW      = $clog2(H_ACTIVE*V_ACTIVE) + 1;

    localparam sync_pol_e POL          = sync_pol_e'(SYNC_POL);
    localparam logic      SYNC_ASSERT  = (POL == SYNC_ACTIVE_HIGH);
    localparam logic      SYNC_IDLE    = !SYNC_ASSERT;

    logic [DW-1:0]      div_q, div_d;
    logic [HW-1:0]      h_q, h_d;
    logic [VW-1:0]      v_q, v_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [PW-1:0]      pixel_cnt_q, pixel_cnt_d;

    logic               tick_q, tick_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_en_q, video_en_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [PW-1:0]      pixel_q, pixel_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    logic               tick;
    logic               h_last;
    logic               v_last;
    raster_flags_t      flags_now;
    raster_flags_t      flags_dly;

    assign tick   = (int'(div_q) == PIXEL_DIV - 1);
    assign h_last = (int'(h_q) == H_TOTAL - 1);
    assign v_last = (int'(v_q) == V_TOTAL - 1);

    // Divider and raster counters; a line wrap and a frame wrap on the same
    // tick are applied together, and the frame count wraps naturally.
    always_comb begin
        div_d   = div_q;
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        if (restart_i) begin
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
        end else if (tick) begin
            div_d = '0;
            if (h_last) begin
                h_d = '0;
                if (v_last) begin
                    v_d     = '0;
                    frame_d = frame_q + 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Decode of the current counter position.
    always_comb begin
        flags_now.act = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
        flags_now.hs  = (int'(h_q) >= H_ACTIVE + H_FP) &&
                        (int'(h_q) <  H_ACTIVE + H_FP + H_SYNC);
        flags_now.vs  = (int'(v_q) >= V_ACTIVE + V_FP) &&
                        (int'(v_q) <  V_ACTIVE + V_FP + V_SYNC);
        flags_now.ls  = (h_q == '0);
        flags_now.fs  = (h_q == '0) && (v_q == '0);
    end

    // The latency stages sit ahead of the output flops so every pin stays a
    // plain register and the strobes can be cut to one clk there.
    generate
        if (LATENCY > 0) begin : g_latency
            tick_delay_line #(
                .WIDTH       ($bits(raster_flags_t)),
                .DEPTH       (LATENCY),
                .RESET_VALUE ('0)
            ) u_flags_delay (
                .clk_i    (clk_i),
                .reset_ni (reset_ni),
                .enable_i (tick),
                .clear_i  (restart_i),
                .data_i   (flags_now),
                .data_o   (flags_dly)
            );
        end else begin : g_no_latency
            assign flags_dly = flags_now;
        end
    endgenerate

    // Output registers. Coordinates use the undelayed decode; pixel address is
    // built by counting visible ticks so no multiplier is needed.
    always_comb begin
        tick_d        = tick && !restart_i;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_en_d    = video_en_q;
        x_d           = x_q;
        y_d           = y_q;
        pixel_d       = pixel_q;
        pixel_cnt_d   = pixel_cnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (restart_i) begin
            hsync_d     = SYNC_IDLE;
            vsync_d     = SYNC_IDLE;
            video_en_d  = 1'b0;
            x_d         = '0;
            y_d         = '0;
            pixel_d     = '0;
            pixel_cnt_d = '0;
        end else if (tick) begin
            hsync_d       = flags_dly.hs ? SYNC_ASSERT : SYNC_IDLE;
            vsync_d       = flags_dly.vs ? SYNC_ASSERT : SYNC_IDLE;
            video_en_d    = flags_dly.act;
            line_start_d  = flags_dly.ls;
            frame_start_d = flags_dly.fs;
            x_d           = flags_now.act ? XW'(h_q) : '0;
            y_d           = flags_now.act ? YW'(v_q) : '0;
            if (flags_now.fs) begin
                pixel_d     = '0;
                pixel_cnt_d = PW'(1);
            end else if (flags_now.act) begin
                pixel_d     = pixel_cnt_q;
                pixel_cnt_d = pixel_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            frame_q       <= '0;
            pixel_cnt_q   <= '0;
            tick_q        <= 1'b0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            video_en_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            pixel_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_q       <= frame_d;
            pixel_cnt_q   <= pixel_cnt_d;
            tick_q        <= tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_en_q    <= video_en_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pixel_q       <= pixel_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign tick_o        = tick_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign video_en_o    = video_en_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign pixel_o       = pixel_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign frame_count_o = frame_q;

endmodule
